fifo_sync_flags: RTL and testbench

- Next-generation synchronous FIFO: parametrised width, depth and almost-full/almost-empty thresholds.
- Adds a registered read port with `data_valid`, an occupancy count, sticky overflow/underflow error flags with software clear, and a synchronous flush.
- Sits between producer/consumer blocks in one clock domain; drop-in buffering for datapath and UART-style streams.

---
 rtl/fifo_sync_flags.sv | 62 ++++++
 tb/tb_fifo_sync_flags.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: synchronous FIFO with registered read port, occupancy count,
// threshold flags, sticky overflow/underflow errors and synchronous flush.
module fifo_sync_flags #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int AF_LEVEL     = 12,
  parameter int AE_LEVEL     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic                    clear_flags,
  input  logic [DATA_SIZE-1:0]    data_in,
  output logic [DATA_SIZE-1:0]    data_out,
  output logic                    data_valid,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);
  localparam logic [ADDRESS_SIZE:0] DEPTH = (ADDRESS_SIZE+1)'(1 << ADDRESS_SIZE);
  localparam logic [ADDRESS_SIZE:0] AF    = (ADDRESS_SIZE+1)'(AF_LEVEL);
  localparam logic [ADDRESS_SIZE:0] AE    = (ADDRESS_SIZE+1)'(AE_LEVEL);
  logic [DATA_SIZE-1:0]    mem [1 << ADDRESS_SIZE];
  logic [ADDRESS_SIZE-1:0] wr_ptr, rd_ptr;
  logic                    pop_ok, push_ok, do_pop, do_push;
  assign full         = count == DEPTH;
  assign empty        = count == '0;
  assign almost_full  = count >= AF;
  assign almost_empty = count <= AE;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // flush suppresses both transfers and any error they would have raised
  assign do_pop  = pop_ok && !flush;
  assign do_push = push_ok && !flush;
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr     <= flush ? '0 : wr_ptr + ADDRESS_SIZE'(do_push);
      rd_ptr     <= flush ? '0 : rd_ptr + ADDRESS_SIZE'(do_pop);
      count      <= flush ? '0 : count + (ADDRESS_SIZE+1)'(do_push) - (ADDRESS_SIZE+1)'(do_pop);
      data_valid <= do_pop;
      if (do_pop) data_out <= mem[rd_ptr];
      overflow   <= (push && !push_ok && !flush) || (overflow && !clear_flags);
      underflow  <= (pop && !pop_ok && !flush) || (underflow && !clear_flags);
    end
  end
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: directed and randomized checks against a queue-based model.
module tb_fifo_sync_flags;
  logic       clk = 1'b0, rst = 1'b0;
  logic       push = 0, pop = 0, flush = 0, clear_flags = 0;
  logic [7:0] data_in = '0, data_out;
  logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  logic [7:0] m_do;
  bit         m_dv, m_ov, m_un;
  logic [7:0] pat = 8'h00;
  fifo_sync_flags dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .clear_flags(clear_flags), .data_in(data_in), .data_out(data_out),
    .data_valid(data_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == 16));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".af"}, 32'(almost_full), 32'(q.size() >= 12));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(q.size() <= 2));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_un));
    chk({tag, ".dv"}, 32'(data_valid), 32'(m_dv));
    chk({tag, ".dout"}, 32'(data_out), 32'(m_do));
  endtask
  task automatic model_reset();
    q.delete();
    m_do = '0; m_dv = 0; m_ov = 0; m_un = 0;
  endtask
  task automatic cycle(input string tag, input bit pu, input bit po, input bit fl,
                       input bit cf, input logic [7:0] d);
    bit pop_ok, push_ok;
    push = pu; pop = po; flush = fl; clear_flags = cf; data_in = d;
    pop_ok  = po && q.size() != 0;
    push_ok = pu && (q.size() < 16 || pop_ok);
    if (fl) begin
      q.delete();
      m_dv = 0;
      if (cf) begin m_ov = 0; m_un = 0; end
    end else begin
      if (pop_ok) m_do = q.pop_front();
      m_dv = pop_ok;
      if (push_ok) q.push_back(d);
      m_ov = (pu && !push_ok) || (m_ov && !cf);
      m_un = (po && !pop_ok) || (m_un && !cf);
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) cycle("fill", 1, 0, 0, 0, 8'(i));
    chk("fill.full16", 32'(full), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      cycle("drain", 0, 1, 0, 0, 8'h00);
      chk("drain.word", 32'(data_out), 32'(i));
    end
    for (int i = 0; i < 16; i++) cycle("refill", 1, 0, 0, 0, 8'(8'h30 + i));
    cycle("fullpp", 1, 1, 0, 0, 8'hAA);
    chk("fullpp.oldest", 32'(data_out), 32'h30);
    for (int i = 0; i < 16; i++) cycle("fullpp.drain", 0, 1, 0, 0, 8'h00);
    chk("fullpp.last", 32'(data_out), 32'hAA);
    cycle("emptypp", 1, 1, 0, 0, 8'h55);
    chk("emptypp.unf", 32'(underflow), 32'd1);
    cycle("emptypp.pop", 0, 1, 0, 0, 8'h00);
    chk("emptypp.word", 32'(data_out), 32'h55);
    cycle("clr_with_set", 0, 1, 0, 1, 8'h00);
    chk("clr_with_set.unf", 32'(underflow), 32'd1);
    cycle("clr_alone", 0, 0, 0, 1, 8'h00);
    chk("clr_alone.unf", 32'(underflow), 32'd0);
    for (int i = 0; i < 5; i++) begin cycle("wrap.pre", 1, 0, 0, 0, pat); pat++; end
    for (int i = 0; i < 40; i++) begin
      bit pu, po;
      pu = q.size() < 9 && ($urandom_range(0, 1) == 1 || q.size() <= 3);
      po = q.size() > 3 && ($urandom_range(0, 1) == 1 || q.size() >= 9);
      cycle("wrap", pu, po, 0, 0, pat);
      if (pu) pat++;
    end
    cycle("flush.pre", 0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 5; i++) cycle("flush.fill", 1, 0, 0, 0, 8'(8'h60 + i));
    cycle("flush", 1, 0, 1, 0, 8'h77);
    chk("flush.count", 32'(count), 32'd0);
    cycle("flush.pop", 0, 1, 0, 0, 8'h00);
    chk("flush.unf", 32'(underflow), 32'd1);
    for (int i = 0; i < 300; i++)
      cycle("rand", $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0, 8'($urandom));
    cycle("ar.flush", 0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 7; i++) cycle("ar.fill", 1, 0, 0, 0, 8'(8'h90 + i));
    cycle("ar.pop", 1, 1, 0, 0, 8'h97);
    chk("ar.count7", 32'(count), 32'd7);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("ar.async");
    @(posedge clk); #1;
    check_all("ar.held");
    push = 0; pop = 0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle("ar.resume", 1, 0, 0, 0, 8'(8'hC0 + i));
    for (int i = 0; i < 4; i++) begin
      cycle("ar.resume.pop", 0, 1, 0, 0, 8'h00);
      chk("ar.resume.word", 32'(data_out), 32'(8'hC0 + i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
